signed_divider_restoring: RTL
=============================

Name: signed_divider_restoring

Overview:
Sequential signed restoring divider, 2N-bit dividend by N-bit divisor; the inverse partner of the team's shift-add signed multiplier. It sits behind the same board UI: switches and buttons load the operands, and the operands and results are mirrored for the HexBoard display. It produces a truncating (toward-zero) quotient and a remainder, one quotient bit per clock.

Parameters:
N, 4, divisor width; dividend and quotient are 2N bits, remainder is N bits.

Ports:
CLK  in  1  single system clock.
RESET  in  1  asynchronous, active-high reset.
DIVIDEND  in  2N  signed dividend, captured on LOAD_DVD.
DIVISOR  in  N  signed divisor, captured on LOAD_DVS.
LOAD_DVD  in  1  level; captures DIVIDEND each cycle it is high while not BUSY.
LOAD_DVS  in  1  level; captures DIVISOR each cycle it is high while not BUSY.
START  in  1  level; rising edge detected internally.
BUSY  out  1  operation in progress.
DONE  out  1  result valid; sticky until the next start or RESET.
QUOTIENT  out  2N  signed quotient.
REMAINDER  out  N  signed remainder; takes the dividend's sign.
DIV_ZERO  out  1  divisor was 0.
OVERFLOW  out  1  quotient is not representable (only -2^(2N-1) / -1).
DVD_OUT  out  2N  latched dividend register.
DVS_OUT  out  N  latched divisor register.
STATE  out  3  encoded FSM state, for the debug hex display.

Behaviour:
- RESET (asynchronous, any state):
  - FSM goes to IDLE.
  - All registers and outputs go to 0, including the edge-detect history.
  - Reset mid-operation aborts it; no DONE is produced.
- START handling:
  - Only a 0->1 transition of START, sampled at CLK, is a start event.
  - Holding START high gives exactly one operation.
  - A start event is accepted in IDLE or DONE and ignored while BUSY.
- Loads:
  - Loads are ignored while BUSY.
  - A load and a start in the same cycle: the load wins, and SETUP uses the newly loaded value.
- FSM states: IDLE(0), SETUP(1), ITER(2), FIXUP(3), DONE(4).
  - IDLE -> SETUP on a start event.
  - SETUP:
    - Record sign_q = dvd_sign XOR dvs_sign, and sign_r = dvd_sign.
    - Load Qreg = |DVD| (2N bits) and Dmag = |DVS| (N+1 bits, so -2^(N-1) is handled).
    - Clear R (N+1 bits) and the counter; assert BUSY.
  - ITER, 2N cycles, one per clock:
    - {R,Qreg} <<= 1.
    - T = R - Dmag.
    - If T >= 0: R = T and Qreg[0] = 1; else R is unchanged and Qreg[0] = 0.
    - After the count reaches 2N-1, go to FIXUP.
  - FIXUP:
    - QUOTIENT = sign_q ? -Qreg : Qreg.
    - REMAINDER = sign_r ? -R[N-1:0] : R[N-1:0].
    - OVERFLOW = (Qreg == 2^(2N-1)) && !sign_q.
  - DONE: DONE=1, BUSY=0; outputs are held until the next start event.
- Latency: a start edge sampled at clock k gives DONE high after clock k+2N+2 (10 cycles for N=4).
- At a start event, DONE, DIV_ZERO and OVERFLOW clear in the same edge that enters SETUP.
- Divisor of 0: DIV_ZERO is set in SETUP. QUOTIENT=0 and REMAINDER=0 are forced at FIXUP, and OVERFLOW=0. Timing depends on the optional feature.
- Dividend of 0: normal path gives Q=0, R=0. No negative zero is possible.

Optional Feature:
DIVIDER_ZERO_TRAP_EN
- Defined: a zero divisor detected in SETUP jumps straight to FIXUP, so DONE comes 2 cycles after the start edge.
- Not defined: the zero-divisor case runs all 2N ITER cycles, giving the normal latency, and results are still forced to 0.
- In both builds DIV_ZERO=1 for a zero divisor.

Decomposition:
- Package divider_pkg holds:
  - the state enum (3-bit encoding above);
  - localparams for the iteration count (2N) and counter width ($clog2(2N)+1).
- One sub-module, div_restoring_step: combinational shift/subtract/select for a single iteration. It takes R, Qreg and Dmag and returns the next R and Qreg, and is instantiated once inside the iterative loop.

Test Plan:
- Load 100 and 7, then a START edge -> DONE on the 10th cycle; QUOTIENT=14 (0x0E), REMAINDER=2, flags 0; BUSY is high for cycles 1-9.
- Sign cases:
  - -100/7 -> Q=-14 (0xF2), R=-2 (0xE).
  - 100/-7 -> Q=0xF2, R=2.
  - -100/-7 -> Q=0x0E, R=0xE.
- Edge cases:
  - -128/-1 -> OVERFLOW=1, Q=0x80, R=0.
  - -128/1 -> Q=0x80, OVERFLOW=0.
  - 127/-8 -> Q=-15 (0xF1), R=7.
- 55/0 -> DIV_ZERO=1, Q=0, R=0; DONE after 2 cycles with DIVIDER_ZERO_TRAP_EN defined, after 10 cycles without.
- START held high for 25 cycles -> exactly one operation. A LOAD_DVD pulse mid-ITER does not change DVD_OUT or the result.
- RESET pulse at the 4th ITER cycle -> all outputs 0 and STATE=0 immediately; a following start with 100/7 returns 14 r 2.

Source files
------------

// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the signed restoring divider.
//   state_t     : FSM state encoding, also shown on the debug hex display
//   DIV_N       : default divisor width
//   iter_count  : number of ITER cycles for a given divisor width (2N)
//   cnt_width   : iteration-counter width for a given divisor width
// ---------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DIV_N = 4;

  // One quotient bit per ITER cycle, 2N quotient bits.
  function automatic int iter_count(input int n);
    return 2 * n;
  endfunction

  // One spare bit so the counter can hold the full iteration count.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// ---------------------------------------------------------------------------
// div_restoring_step
// One restoring-division iteration on unsigned magnitudes (combinational).
//   r      in  N+1  partial remainder
//   q      in  2N   dividend/quotient shift register
//   dmag   in  N+1  divisor magnitude
//   r_next out N+1  partial remainder after shift/subtract/restore
//   q_next out 2N   shift register with the new quotient bit in bit 0
// ---------------------------------------------------------------------------
module div_restoring_step #(
  parameter int N = 4
) (
  input  logic [N:0]     r,
  input  logic [2*N-1:0] q,
  input  logic [N:0]     dmag,
  output logic [N:0]     r_next,
  output logic [2*N-1:0] q_next
);

  // One extra bit keeps the shifted remainder exact, so the compare below is
  // the sign test of T = R - Dmag without a separate borrow bit.
  logic [N+1:0] r_sh;
  logic         fits;

  always_comb begin
    r_sh   = {r, q[2*N-1]};
    fits   = (r_sh >= {1'b0, dmag});
    r_next = r_sh[N:0];
    q_next = {q[2*N-2:0], 1'b0};
    if (fits) begin
      r_next = (N+1)'(r_sh - {1'b0, dmag});
      q_next = {q[2*N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/signed_divider_restoring.sv
// ---------------------------------------------------------------------------
// signed_divider_restoring
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor,
// truncating quotient, remainder carries the dividend's sign.
// Optional build macro: DIVIDER_ZERO_TRAP_EN (zero divisor skips ITER).
//   CLK        in   1   system clock
//   RESET      in   1   asynchronous active-high reset
//   DIVIDEND   in   2N  signed dividend, captured on LOAD_DVD
//   DIVISOR    in   N   signed divisor, captured on LOAD_DVS
//   LOAD_DVD   in   1   level load of DIVIDEND when not busy
//   LOAD_DVS   in   1   level load of DIVISOR when not busy
//   START      in   1   rising edge starts an operation
//   BUSY       out  1   operation in progress
//   DONE       out  1   result valid, sticky until next start
//   QUOTIENT   out  2N  signed quotient
//   REMAINDER  out  N   signed remainder
//   DIV_ZERO   out  1   divisor was zero
//   OVERFLOW   out  1   quotient not representable (-2^(2N-1) / -1)
//   DVD_OUT    out  2N  latched dividend
//   DVS_OUT    out  N   latched divisor
//   STATE      out  3   FSM state for the debug display
// ---------------------------------------------------------------------------
module signed_divider_restoring
  import divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [2*N-1:0] DIVIDEND,
  input  logic [N-1:0]   DIVISOR,
  input  logic           LOAD_DVD,
  input  logic           LOAD_DVS,
  input  logic           START,
  output logic           BUSY,
  output logic           DONE,
  output logic [2*N-1:0] QUOTIENT,
  output logic [N-1:0]   REMAINDER,
  output logic           DIV_ZERO,
  output logic           OVERFLOW,
  output logic [2*N-1:0] DVD_OUT,
  output logic [N-1:0]   DVS_OUT,
  output logic [2:0]     STATE
);

  localparam int ITERS = iter_count(N);
  localparam int CW    = cnt_width(N);

  state_t         state;
  logic           start_prev;
  logic [2*N-1:0] dvd_reg;
  logic [N-1:0]   dvs_reg;
  logic [2*N-1:0] qreg;
  logic [N:0]     rreg;
  logic [N:0]     dmag;
  logic [CW-1:0]  cnt;
  logic           sign_q;
  logic           sign_r;

  logic           start_evt;
  logic           accepting;
  logic [2*N-1:0] dvd_abs;
  logic [N:0]     dvs_ext;
  logic [N:0]     dvs_abs;
  logic [N:0]     r_next;
  logic [2*N-1:0] q_next;

  assign start_evt = START & ~start_prev;
  assign accepting = (state == S_IDLE) || (state == S_DONE);

  // Divisor magnitude is N+1 bits so that -2^(N-1) becomes +2^(N-1).
  assign dvd_abs = dvd_reg[2*N-1] ? -dvd_reg : dvd_reg;
  assign dvs_ext = {dvs_reg[N-1], dvs_reg};
  assign dvs_abs = dvs_ext[N] ? -dvs_ext : dvs_ext;

  assign DVD_OUT = dvd_reg;
  assign DVS_OUT = dvs_reg;
  assign STATE   = state;

  div_restoring_step #(.N(N)) u_step (
    .r      (rreg),
    .q      (qreg),
    .dmag   (dmag),
    .r_next (r_next),
    .q_next (q_next)
  );

  // Operand registers: loads only land when no operation is in flight, and a
  // load in the start cycle is visible to SETUP on the following edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dvd_reg <= '0;
      dvs_reg <= '0;
    end else if (accepting) begin
      // NOTE: state uses non-blocking assignments so every register updates
      // from pre-edge values; blocking here would chain same-cycle updates.
      if (LOAD_DVD) dvd_reg <= DIVIDEND;
      if (LOAD_DVS) dvs_reg <= DIVISOR;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: every register, datapath included, is reset so an aborted
      // operation leaves nothing stale on the display.
      state      <= S_IDLE;
      start_prev <= 1'b0;
      qreg       <= '0;
      rreg       <= '0;
      dmag       <= '0;
      cnt        <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      QUOTIENT   <= '0;
      REMAINDER  <= '0;
      DIV_ZERO   <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      start_prev <= START;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_evt) begin
            state    <= S_SETUP;
            DONE     <= 1'b0;
            DIV_ZERO <= 1'b0;
            OVERFLOW <= 1'b0;
          end
        end
        S_SETUP: begin
          sign_q   <= dvd_reg[2*N-1] ^ dvs_reg[N-1];
          sign_r   <= dvd_reg[2*N-1];
          qreg     <= dvd_abs;
          dmag     <= dvs_abs;
          rreg     <= '0;
          cnt      <= '0;
          BUSY     <= 1'b1;
          DIV_ZERO <= (dvs_reg == '0);
`ifdef DIVIDER_ZERO_TRAP_EN
          state    <= (dvs_reg == '0) ? S_FIXUP : S_ITER;
`else
          state    <= S_ITER;
`endif
        end
        S_ITER: begin
          rreg <= r_next;
          qreg <= q_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          if (DIV_ZERO) begin
            QUOTIENT  <= '0;
            REMAINDER <= '0;
            OVERFLOW  <= 1'b0;
          end else begin
            QUOTIENT  <= sign_q ? -qreg : qreg;
            REMAINDER <= sign_r ? -rreg[N-1:0] : rreg[N-1:0];
            // Only a positive 2^(2N-1) magnitude cannot be represented.
            OVERFLOW  <= (qreg == {1'b1, {(2*N-1){1'b0}}}) && !sign_q;
          end
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
